// File: rtl/div_signed_seq.sv
// rtl/div_signed_seq.sv - sequential signed 16/8 divider, restoring, fixed 18-cycle latency
module div_signed_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [7:0]  b,
    output logic [7:0]  q,
    output logic [7:0]  r,
    output logic        busy,
    output logic        ready,
    output logic        ovf,
    output logic        dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  cnt;
    // Dividend magnitude shifts out of the MSB while quotient bits shift in at the LSB,
    // so after 16 iterations this register holds the magnitude quotient.
    logic [15:0] dvd;
    logic [8:0]  rem;
    logic [7:0]  b_mag;
    logic        q_neg;
    logic        r_neg;
    logic        b_zero;

    logic [9:0]  rem_shift;
    logic        sub_ok;
    logic [8:0]  rem_next;
    logic [7:0]  q_fix;
    logic [7:0]  r_fix;
    logic        q_ovf;

    // Next-state logic: 16 CALC cycles, then one SIGN cycle to publish results
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = CALC;
            CALC: if (cnt == 5'd15) state_next = SIGN;
            SIGN: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One restoring step plus the sign fix-up applied to the magnitude results
    always_comb begin
        rem_shift = {rem, dvd[15]};
        sub_ok    = (rem_shift >= {2'b00, b_mag});
        rem_next  = sub_ok ? (rem_shift[8:0] - {1'b0, b_mag}) : rem_shift[8:0];
        // Low 8 bits of a negation depend only on the low 8 bits of the operand
        q_fix     = q_neg ? (8'd0 - dvd[7:0]) : dvd[7:0];
        r_fix     = r_neg ? (8'd0 - rem[7:0]) : rem[7:0];
        // A negative quotient may reach -128; a positive one only 127
        q_ovf     = q_neg ? (dvd > 16'd128) : (dvd > 16'd127);
    end

    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, iteration datapath and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 5'd0;
            dvd    <= 16'd0;
            rem    <= 9'd0;
            b_mag  <= 8'd0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            b_zero <= 1'b0;
            q      <= 8'd0;
            r      <= 8'd0;
            ovf    <= 1'b0;
            dz     <= 1'b0;
            ready  <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd    <= a[15] ? (16'd0 - a) : a;
                        b_mag  <= b[7] ? (8'd0 - b) : b;
                        q_neg  <= a[15] ^ b[7];
                        r_neg  <= a[15];
                        b_zero <= (b == 8'd0);
                        rem    <= 9'd0;
                        cnt    <= 5'd0;
                    end
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    dvd <= {dvd[14:0], sub_ok};
                    rem <= rem_next;
                end
                SIGN: begin
                    ready <= 1'b1;
                    if (b_zero) begin
                        q   <= 8'd0;
                        r   <= 8'd0;
                        ovf <= 1'b0;
                        dz  <= 1'b1;
                    end else begin
                        q   <= q_fix;
                        r   <= r_fix;
                        ovf <= q_ovf;
                        dz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_signed_seq.sv
// tb/tb_div_signed_seq.sv - self-checking bench for div_signed_seq
module tb_div_signed_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        busy;
    logic        ready;
    logic        ovf;
    logic        dz;

    int passed = 0;
    int total  = 0;

    div_signed_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .ready (ready),
        .ovf   (ovf),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    // Reference: integer division truncating toward zero, packed as {q, r, ovf, dz}
    function automatic logic [17:0] model(input logic [15:0] av, input logic [7:0] bv);
        int ai;
        int bi;
        int qt;
        int rt;
        logic [7:0] qb;
        logic [7:0] rb;
        logic ov;
        ai = int'($signed(av));
        bi = int'($signed(bv));
        if (bi == 0) return {8'h00, 8'h00, 1'b0, 1'b1};
        qt = ai / bi;
        rt = ai % bi;
        ov = (qt > 127) || (qt < -128);
        qb = qt[7:0];
        rb = rt[7:0];
        return {qb, rb, ov, 1'b0};
    endfunction

    // Runs one division from a negedge; samples each following negedge for 22 cycles
    task automatic do_op(input logic [15:0] av, input logic [7:0] bv, input bit mid_start,
                         output logic [17:0] res, output int ready_at,
                         output int ready_cnt, output int busy_cnt);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom);
        b = 8'($urandom);
        res = 'x;
        ready_at = -1;
        ready_cnt = 0;
        busy_cnt = 0;
        for (int n = 0; n < 22; n++) begin
            if (busy === 1'b1) busy_cnt++;
            if (ready === 1'b1) begin
                ready_cnt++;
                if (ready_at < 0) ready_at = n;
                res = {q, r, ovf, dz};
            end
            if (mid_start && n == 5) begin
                start = 1'b1;
                a = 16'($urandom);
                b = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        total++;
        if ({q, r, busy, ready, ovf, dz} !== 20'd0) begin
            $display("FAIL reset_state: got %h expected 0", {q, r, busy, ready, ovf, dz});
        end else passed++;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [17:0] res;
        int ra, rc, bc;
        do_op(16'd100, 8'd7, 1'b0, res, ra, rc, bc);
        total++;
        if (res !== {8'h0E, 8'h02, 1'b0, 1'b0}) $display("FAIL basic_result: got %h expected %h", res, {8'h0E, 8'h02, 2'b00});
        else passed++;
        total++;
        if (ra !== 17) $display("FAIL basic_latency: got %0d expected 17", ra);
        else passed++;
        total++;
        if (rc !== 1) $display("FAIL basic_ready_count: got %0d expected 1", rc);
        else passed++;
        total++;
        if (bc !== 17) $display("FAIL basic_busy_cycles: got %0d expected 17", bc);
        else passed++;
    endtask

    task automatic test_signs;
        logic [15:0] ta [3] = '{16'hFF9C, 16'd100, 16'hFF9C};
        logic [7:0]  tb [3] = '{8'd7, 8'hF9, 8'hF9};
        logic [7:0]  eq [3] = '{8'hF2, 8'hF2, 8'h0E};
        logic [7:0]  er [3] = '{8'hFE, 8'h02, 8'hFE};
        logic [17:0] res;
        int ra, rc, bc;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], 1'b0, res, ra, rc, bc);
            total++;
            if (res[17:10] !== eq[i]) $display("FAIL sign_q[%0d]: got %h expected %h", i, res[17:10], eq[i]);
            else passed++;
            total++;
            if (res[9:2] !== er[i]) $display("FAIL sign_r[%0d]: got %h expected %h", i, res[9:2], er[i]);
            else passed++;
        end
    endtask

    task automatic test_boundaries;
        logic [17:0] res;
        int ra, rc, bc;
        do_op(16'hFF80, 8'h01, 1'b0, res, ra, rc, bc);
        total++;
        if ({res[17:10], res[1]} !== {8'h80, 1'b0}) $display("FAIL bound_neg128: got q=%h ovf=%b expected q=80 ovf=0", res[17:10], res[1]);
        else passed++;
        do_op(16'h0080, 8'h01, 1'b0, res, ra, rc, bc);
        total++;
        if ({res[17:10], res[1]} !== {8'h80, 1'b1}) $display("FAIL bound_pos128: got q=%h ovf=%b expected q=80 ovf=1", res[17:10], res[1]);
        else passed++;
        do_op(16'h8000, 8'hFF, 1'b0, res, ra, rc, bc);
        total++;
        if ({res[9:2], res[1]} !== {8'h00, 1'b1}) $display("FAIL bound_min_div_m1: got r=%h ovf=%b expected r=00 ovf=1", res[9:2], res[1]);
        else passed++;
    endtask

    task automatic test_div_zero;
        logic [17:0] res;
        int ra, rc, bc;
        do_op(16'd1000, 8'd0, 1'b0, res, ra, rc, bc);
        total++;
        if (res !== {8'h00, 8'h00, 1'b0, 1'b1}) $display("FAIL div_zero_result: got %h expected %h", res, {16'h0000, 2'b01});
        else passed++;
        total++;
        if (ra !== 17) $display("FAIL div_zero_latency: got %0d expected 17", ra);
        else passed++;
    endtask

    task automatic test_random;
        logic [17:0] res;
        logic [15:0] av;
        logic [7:0]  bv;
        int ra, rc, bc;
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) av = 16'($urandom);
            else av = 16'($urandom_range(0, 4000) - 2000);
            bv = 8'($urandom);
            do_op(av, bv, 1'b0, res, ra, rc, bc);
            total++;
            if (res !== model(av, bv) || ra !== 17 || rc !== 1)
                $display("FAIL random[%0d] a=%h b=%h: got %h at %0d (x%0d) expected %h at 17 (x1)", i, av, bv, res, ra, rc, model(av, bv));
            else passed++;
        end
    endtask

    task automatic test_mid_start;
        logic [17:0] res;
        int ra, rc, bc;
        do_op(16'hF123, 8'h35, 1'b1, res, ra, rc, bc);
        total++;
        if (res !== model(16'hF123, 8'h35)) $display("FAIL mid_start_result: got %h expected %h", res, model(16'hF123, 8'h35));
        else passed++;
        total++;
        if (rc !== 1 || ra !== 17) $display("FAIL mid_start_ready: got %0d pulses first at %0d expected 1 at 17", rc, ra);
        else passed++;
    endtask

    task automatic test_mid_reset;
        logic [17:0] res;
        int ra, rc, bc;
        int stray;
        a = 16'd500;
        b = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({q, r, busy, ready, ovf, dz} !== 20'd0) $display("FAIL mid_reset_outputs: got %h expected 0", {q, r, busy, ready, ovf, dz});
        else passed++;
        rst = 1'b0;
        stray = 0;
        for (int n = 0; n < 20; n++) begin
            if (ready === 1'b1 || busy === 1'b1) stray++;
            @(negedge clk);
        end
        total++;
        if (stray !== 0) $display("FAIL mid_reset_quiet: got %0d active cycles expected 0", stray);
        else passed++;
        do_op(16'hFC00, 8'd11, 1'b0, res, ra, rc, bc);
        total++;
        if (res !== model(16'hFC00, 8'd11) || ra !== 17) $display("FAIL mid_reset_next_op: got %h at %0d expected %h at 17", res, ra, model(16'hFC00, 8'd11));
        else passed++;
    endtask

    task automatic test_reset_priority;
        logic [17:0] res;
        int ra, rc, bc;
        rst = 1'b1;
        start = 1'b1;
        a = 16'd77;
        b = 8'd3;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("FAIL reset_priority_busy: got %b expected 0", busy);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_op(16'd77, 8'd3, 1'b0, res, ra, rc, bc);
        total++;
        if (res !== model(16'd77, 8'd3) || ra !== 17) $display("FAIL start_after_reset: got %h at %0d expected %h at 17", res, ra, model(16'd77, 8'd3));
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [17:0] exp_q [$];
        logic [17:0] expv;
        int last;
        int done;
        a = 16'($urandom_range(0, 3000));
        b = 8'($urandom_range(1, 60));
        exp_q.push_back(model(a, b));
        start = 1'b1;
        @(negedge clk);
        last = -1;
        done = 0;
        for (int n = 0; n < 120 && done < 4; n++) begin
            if (ready === 1'b1) begin
                expv = exp_q.pop_front();
                total++;
                if ({q, r, ovf, dz} !== expv || busy !== 1'b0) $display("FAIL b2b_result[%0d]: got %h busy=%b expected %h busy=0", done, {q, r, ovf, dz}, busy, expv);
                else passed++;
                if (last >= 0) begin
                    total++;
                    if (n - last !== 18) $display("FAIL b2b_interval[%0d]: got %0d expected 18", done, n - last);
                    else passed++;
                end
                last = n;
                done++;
                if (done < 4) begin
                    a = 16'($urandom);
                    b = 8'($urandom);
                    exp_q.push_back(model(a, b));
                end else begin
                    start = 1'b0;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        if (done !== 4) $display("FAIL b2b_count: got %0d expected 4", done);
        else passed++;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = 16'd0;
        b = 8'd0;
        repeat (3) @(negedge clk);
        test_reset;
        test_basic;
        test_signs;
        test_boundaries;
        test_div_zero;
        test_random;
        test_mid_start;
        test_mid_reset;
        test_reset_priority;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/div_signed_seq.md
DIV_SIGNED_SEQ -- requirements
Module: div_signed_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  Rising-edge clock; the only clock in the block.
REQ-003 rst  input  1  Synchronous, active-high reset.
REQ-004 start  input  1  Request to begin a division; sampled only in IDLE.
REQ-005 a  input  16  Signed two's-complement dividend; captured when start is accepted.
REQ-006 b  input  8  Signed two's-complement divisor; captured when start is accepted.
REQ-007 q  output  8  Signed quotient, registered.
REQ-008 r  output  8  Signed remainder, registered.
REQ-009 busy  output  1  High while a division is in progress.
REQ-010 ready  output  1  One-cycle pulse when q, r, ovf and dz are valid.
REQ-011 ovf  output  1  The true quotient lies outside -128..127.
REQ-012 dz  output  1  The divisor was zero.

Function
REQ-013 The block SHALL implement states IDLE, CALC and SIGN, with the following transitions:
- IDLE -> CALC on start=1.
- CALC -> SIGN after 16 iterations.
- SIGN -> IDLE unconditionally.
REQ-014 On start acceptance, the block SHALL capture a and b and load the magnitudes |a| (16-bit unsigned) and |b| (8-bit unsigned), the result signs (sign(a) XOR sign(b) for q; sign(a) for r), and a 5-bit iteration counter set to 0.
REQ-015 The block SHALL perform one iteration of unsigned restoring division per CALC cycle, MSB first:
- Shift the partial remainder left and bring in the next dividend bit.
- Subtract |b|.
- If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the quotient bit to 0.
REQ-016 The partial remainder SHALL be 9 bits wide and the magnitude quotient 16 bits wide, so that |a|=32768 is handled correctly.
REQ-017 In SIGN, the block SHALL apply signs to the magnitude results:
- q = low 8 bits of the signed quotient, truncated toward zero.
- r = remainder carrying the sign of a, with |r| < |b|.
REQ-018 ovf SHALL be 1 when the signed quotient is outside -128..127; q still holds its low 8 bits, and r remains exact.
REQ-019 When b=0, the block SHALL keep the same 18-cycle latency and produce q=8'h00, r=8'h00, dz=1, ovf=0.
REQ-020 Latency SHALL be fixed: with start accepted at edge k, busy=1 in the cycles following edges k through k+16, and ready=1 for exactly the one cycle following edge k+17.
REQ-021 busy SHALL be 0 in the ready cycle, so a new start may be accepted at edge k+18.
REQ-022 start while busy SHALL be ignored, with no effect on the operation in progress or on its captured operands.
REQ-023 q, r, ovf and dz SHALL update only at the SIGN edge and hold their values until the next SIGN edge or reset.
REQ-024 Changes on a and b after start acceptance SHALL have no effect on the operation in progress.

Reset
REQ-025 With rst=1 at a rising edge, the block SHALL enter IDLE with q=0, r=0, busy=0, ready=0, ovf=0, dz=0, counter=0; this also applies mid-operation, which aborts the operation with no ready pulse.
REQ-026 When rst and start are both high at the same edge, rst SHALL take priority and the start SHALL be dropped.
REQ-027 In the first cycle after rst deasserts, the block SHALL accept start normally.

Verification
REQ-028 a=16'd100, b=8'd7 -> after 18 cycles: ready pulse, q=8'h0E, r=8'h02, ovf=0, dz=0; busy high for exactly 17 cycles.
REQ-029 Sign combinations, each checked for q and r:
- a=-100, b=7 -> q=8'hF2, r=8'hFE.
- a=100, b=-7 -> q=8'hF2, r=8'h02.
- a=-100, b=-7 -> q=8'h0E, r=8'hFE.
REQ-030 Range boundaries, each checked for q and ovf:
- a=16'hFF80, b=8'h01 -> q=8'h80, ovf=0.
- a=16'h0080, b=8'h01 -> q=8'h80, ovf=1.
- a=16'h8000, b=8'hFF -> ovf=1, r=0.
REQ-031 a=16'd1000, b=0 -> dz=1, q=8'h00, r=8'h00, ovf=0, ready at the 18-cycle latency.
REQ-032 Control boundaries:
- start pulsed mid-CALC with different operands -> first result unchanged, no extra ready pulse.
- rst asserted mid-CALC -> all outputs 0, no ready pulse, and the next start completes correctly.
REQ-033 Back-to-back operation: start held high continuously -> a new operation is accepted every 18 cycles, each producing exactly one ready pulse.
